// File: rtl/command_merger.sv
// Return-path merger: qualifies the selected command bus for STABLE_CYCLES samples,
// then forwards one command per assertion to the mbed over a valid/ack handshake.
module command_merger #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       select,
  input  logic [6:0] controller_cmd,
  input  logic [6:0] maintenance_cmd,
  input  logic       mbed_ack,
  output logic [6:0] mbed_cmd,
  output logic       mbed_valid,
  output logic       source,
  output logic       timeout_err
);

  localparam logic [6:0] CTRL_IDLE  = 7'b1101110;
  localparam logic [6:0] MAINT_IDLE = 7'b0111111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0]  STABLE_LIM  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [6:0]  cand_q, cand_d;
  logic [3:0]  stable_q, stable_d;
  logic [15:0] tmo_q, tmo_d;
  logic [6:0]  cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic        source_q, source_d;
  logic        terr_q, terr_d;
  logic        sel_prev_q;

  logic [6:0] active_cmd;
  logic [6:0] active_idle;
  logic       cmd_is_idle;

  assign active_cmd  = select ? maintenance_cmd : controller_cmd;
  assign active_idle = select ? MAINT_IDLE : CTRL_IDLE;
  assign cmd_is_idle = (active_cmd == active_idle);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    cmd_d    = cmd_q;
    valid_d  = valid_q;
    source_d = source_q;
    terr_d   = 1'b0;

    if (select != sel_prev_q) begin
      // Source switch abandons everything; the new bus is looked at from the next edge.
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      stable_d = '0;
      tmo_d    = '0;
      cmd_d    = active_idle;
    end else begin
      case (state_q)
        ST_IDLE, ST_QUALIFY: begin
          cmd_d   = active_idle;
          valid_d = 1'b0;
          if (cmd_is_idle) begin
            state_d  = ST_IDLE;
            stable_d = '0;
          end else begin
            state_d = ST_QUALIFY;
            if (state_q == ST_QUALIFY && active_cmd == cand_q) begin
              stable_d = stable_q + 4'd1;
            end else begin
              cand_d   = active_cmd;
              stable_d = 4'd1;
            end
            if (stable_d == STABLE_LIM) begin
              state_d  = ST_SEND;
              cmd_d    = cand_d;
              valid_d  = 1'b1;
              source_d = select;
              tmo_d    = '0;
              stable_d = '0;
            end
          end
        end
        ST_SEND: begin
          if (mbed_ack) begin
            state_d = ST_RELEASE;
            valid_d = 1'b0;
            cmd_d   = active_idle;
            tmo_d   = '0;
          end else if (tmo_q + 16'd1 == TIMEOUT_LIM) begin
            state_d = ST_RELEASE;
            valid_d = 1'b0;
            terr_d  = 1'b1;
            cmd_d   = active_idle;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        default: begin
          // Hold off until the bus goes idle so a held command is sent only once.
          cmd_d   = active_idle;
          valid_d = 1'b0;
          if (cmd_is_idle) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      stable_q   <= '0;
      tmo_q      <= '0;
      cmd_q      <= CTRL_IDLE;
      valid_q    <= 1'b0;
      source_q   <= 1'b0;
      terr_q     <= 1'b0;
      sel_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      source_q   <= source_d;
      terr_q     <= terr_d;
      sel_prev_q <= select;
    end
  end

  assign mbed_cmd    = cmd_q;
  assign mbed_valid  = valid_q;
  assign source      = source_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/command_merger.md
# command_merger

Return-path merger for the chip dispenser's mbed command bus: accepts the two 7-bit command buses from the controller (normal mode) and maintenance logic, and forwards exactly one validated command at a time to the mbed with a valid/ack handshake. The mode select chooses the live source. Commands must be stable for a programmable number of cycles before acceptance, and each accepted command is sent once per assertion. The opposite-source bus and the idle codes are ignored.

## Interface
- STABLE_CYCLES, 3, consecutive identical non-idle samples required before a command is accepted (1..15)
- TIMEOUT, 255, cycles mbed_valid may wait for mbed_ack before the command is dropped (1..65535)
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- select  input  1  0 = controller source, 1 = maintenance source
- controller_cmd  input  7  controller command; idle code 7'b1101110
- maintenance_cmd  input  7  maintenance command; idle code 7'b0111111
- mbed_ack  input  1  mbed has consumed mbed_cmd
- mbed_cmd  output  7  command to mbed; idle code of selected source when nothing is pending
- mbed_valid  output  1  mbed_cmd holds an accepted command
- source  output  1  select value latched at acceptance
- timeout_err  output  1  one-cycle pulse when a command is dropped for lack of ack

## Operation
- Active command = controller_cmd if select=0, else maintenance_cmd. Active idle code = 7'b1101110 (select=0) or 7'b0111111 (select=1).
- FSM states: IDLE, QUALIFY, SEND, RELEASE.
- IDLE: mbed_valid=0, mbed_cmd = active idle code. Active command ≠ active idle code → latch it as candidate, stable count=1, go QUALIFY.
- QUALIFY: active command == candidate → count+1; count reaching STABLE_CYCLES → latch mbed_cmd=candidate, source=select, mbed_valid=1, timeout counter=0, go SEND. Active command changes to another non-idle value → new candidate, count=1, stay. Returns to idle code → IDLE.
- SEND: mbed_valid=1, mbed_cmd frozen. mbed_ack=1 → mbed_valid=0, go RELEASE. Otherwise timeout counter+1; counter reaching TIMEOUT → mbed_valid=0, timeout_err=1 for one cycle, go RELEASE.
- RELEASE: mbed_valid=0, mbed_cmd = active idle code. Stays until active command equals active idle code, then IDLE. A command held asserted is therefore sent only once.
- select differs from its value at the previous edge (any state) → abandon: mbed_valid=0, counters cleared, go IDLE; no timeout_err. The newly selected source is evaluated from the following cycle.
- mbed_ack outside SEND is ignored.
- Inactive source bus never affects state or outputs.
- Counters: stable count 4 bits, timeout 16 bits; neither wraps (the transition fires on reaching the limit).

## Timing
- Reset values: mbed_cmd=7'b1101110, mbed_valid=0, source=0, timeout_err=0, FSM=IDLE, counters=0, select history=0.
- All outputs registered; no combinational input-to-output path.
- Acceptance latency: command first sampled at edge N, unchanged → mbed_valid=1 after edge N+STABLE_CYCLES-1. With STABLE_CYCLES=1, valid after edge N.
- Handshake: mbed_ack sampled high at edge M while mbed_valid=1 → mbed_valid=0 after edge M. Ack coincident with timeout limit: ack wins, no timeout_err.
- Timeout: mbed_valid high for exactly TIMEOUT cycles without ack, then drops with timeout_err high for one cycle.
- select toggle at the same edge as ack or timeout: select abort wins (IDLE, no timeout_err).
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronous); no partial command is resent after reset release.

## Test plan
- Reset with controller_cmd=7'h05, select=0: mbed_cmd=7'b1101110, valid=0. Release reset → valid=1 with mbed_cmd=7'h05 after 3 edges, source=0.
- select=1, maintenance_cmd=7'h12 held 2 cycles then 7'h13 held 3 cycles: only 7'h13 is forwarded. Controller bus toggling meanwhile has no effect.
- Command accepted, ack on the 2nd valid cycle: valid drops the next cycle. Command held 20 more cycles → no resend. Return to idle then reapply → second send.
- No ack, TIMEOUT=8: valid high exactly 8 cycles, then timeout_err pulse for 1 cycle. Ack arriving later is ignored.
- Toggle select while in SEND: valid drops, no timeout_err. mbed_cmd becomes the new source's idle code.
- Deassert rst_n mid-SEND: outputs reset asynchronously. After release with the command still asserted, it re-qualifies (full STABLE_CYCLES) before sending.
